nios_cpu_mul_sequencer: RTL and testbench
=========================================

Name: nios_cpu_mul_sequencer

Overview:
- Sequences the shared three-partial-product 16x16 multiplier cell (outputs p1 = lo*lo, p2 = lo(src1)*hi(src2), p3 = hi(src1)*lo(src2)) to produce full Nios II multiply results.
- Supported operations: MUL, MULXUU, MULXSS, MULXSU.
- Accepts one request at a time over valid/ready.
- Drives the cell operands and enable, waits for the cell's pipeline latency, and accumulates partial products into a 64-bit sum.
- Applies signed correction for the high-word ops, then returns the 32-bit result over valid/ready.

Parameters:
- CELL_LATENCY, 1: cycles from cell_en=1 until cell_p1..p3 reflect the driven operands. Legal range 1..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (src1 signed, src2 unsigned)
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  32  result word
- cell_src1  out  32  to cell E_src1
- cell_src2  out  32  to cell E_src2
- cell_en  out  1  to cell M_en
- cell_p1, cell_p2, cell_p3  in  32 each  from cell

Behaviour:
- Reset values (reset_n low at a clk edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, cell_en=0, cell_src1/2=0.
  - Accumulator and wait counter are cleared.
  - Any in-flight operation is discarded with no response.
- Handshakes:
  - req_ready = (state==IDLE).
  - A request transfers on req_valid&req_ready; op, src1 and src2 are latched.
  - Response transfers on rsp_valid&rsp_ready.
  - No request is accepted in the same cycle a response retires.
- States:
  - IDLE: on accept -> LO.
  - LO: one cycle. cell_src1=A, cell_src2=B, cell_en=1. Load wait counter = CELL_LATENCY-1 -> LO_WAIT.
  - LO_WAIT:
    - cell_en=0 and operands held.
    - Decrement counter.
    - When the count reaches 0 and the cell outputs are valid: acc = p1 + (p2<<16) + (p3<<16), computed at 64-bit width with zero-extended partials.
    - If op==MUL -> RESP; otherwise -> HI.
  - HI: one cycle. cell_src1={16'h0,A[31:16]}, cell_src2={16'h0,B[31:16]}, cell_en=1. Reload counter -> HI_WAIT.
  - HI_WAIT:
    - Same wait rule as LO_WAIT.
    - acc += p1<<32.
    - Compute high = acc[63:32].
    - Signed correction, all mod 2^32:
      - MULXSS: high -= (A[31]?B:0) + (B[31]?A:0).
      - MULXSU: high -= (A[31]?B:0).
      - MULXUU: no correction.
    - -> RESP.
  - RESP:
    - rsp_valid=1; rsp_result is the low word (MUL) or the corrected high word.
    - Result is held stable while rsp_ready=0.
    - On rsp_ready -> IDLE.
- Latency, from the accepting edge to the first cycle rsp_valid=1:
  - MUL: 2+CELL_LATENCY cycles (3 at the default).
  - High-word ops: 3+2*CELL_LATENCY cycles (5 at the default).
- cell_en pulses: exactly one per MUL and exactly two per high-word op. cell_en is never asserted outside LO/HI, so the cell outputs stay frozen during waits and backpressure.
- Arithmetic: all intermediate sums are 64-bit unsigned; overflow beyond bit 63 is discarded.
- Mid-operation reset: takes effect at the next edge in every state, including RESP under backpressure.
- Request inputs are don't-care outside the accept cycle.

Decomposition:
- Shared package nios_cpu_mul_pkg holds:
  - op encodings MUL/MULXUU/MULXSS/MULXSU
  - the state enum IDLE/LO/LO_WAIT/HI/HI_WAIT/RESP
  - constant CELL_LATENCY_MAX=3
- Natural sub-module: nios_cpu_mul_fixup, combinational. Inputs: 64-bit acc, op, A, B. Output: the 32-bit result (low word or corrected high word).
- The multiplier cell is instantiated by the parent, not inside this block.

Test Plan:
- MUL A=0x0001_0003, B=0x0002_0005 -> rsp_result=0x000B_000F, rsp_valid 3 cycles after accept, one cell_en pulse.
- MULXUU A=B=0xFFFF_FFFF -> rsp_result=0xFFFF_FFFE, rsp_valid 5 cycles after accept, two cell_en pulses.
- MULXSS A=B=0xFFFF_FFFF -> 0x0000_0000. MULXSS A=0x8000_0000, B=0x0000_0002 -> 0xFFFF_FFFF.
- MULXSU A=0xFFFF_FFFF, B=0x0000_0002 -> 0xFFFF_FFFF. MULXSU A=0x0000_0002, B=0xFFFF_FFFF -> 0x0000_0001.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid=1, result stable, req_ready=0, cell_en=0. Release -> IDLE next cycle, then a back-to-back request is accepted.
- Reset: drive reset_n low for one cycle during HI_WAIT -> next cycle req_ready=1, rsp_valid=0, cell_en=0, and no response is produced. Repeat with CELL_LATENCY=3: MUL latency 5, high-word latency 9.

Source files
------------

// File: rtl/nios_cpu_mul_pkg.sv
// Shared encodings for the Nios II multiply sequencer: op codes, FSM states,
// and the wait-counter sizing derived from the deepest supported cell pipeline.
package nios_cpu_mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULXUU = 2'b01,
        MULXSS = 2'b10,
        MULXSU = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        LO_WAIT,
        HI,
        HI_WAIT,
        RESP
    } mul_state_e;

    localparam int CELL_LATENCY_MAX = 3;
    localparam int CNT_W            = $clog2(CELL_LATENCY_MAX);

endpackage

// File: rtl/nios_cpu_mul_fixup.sv
// Result selection: low product word for MUL, or the high word of the unsigned
// product corrected into a signed/mixed high word for MULXSS/MULXSU.
module nios_cpu_mul_fixup
    import nios_cpu_mul_pkg::*;
(
    input  logic [63:0] i_acc,
    input  mul_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic [31:0] w_corr;

    // Signed high word = unsigned high word minus the operand contributed by each negative sign bit
    always_comb begin
        w_corr = '0;
        case (i_op)
            MULXSS:  w_corr = (i_a[31] ? i_b : 32'd0) + (i_b[31] ? i_a : 32'd0);
            MULXSU:  w_corr = i_a[31] ? i_b : 32'd0;
            default: w_corr = '0;
        endcase
        o_result = (i_op == MUL) ? i_acc[31:0] : (i_acc[63:32] - w_corr);
    end

endmodule

// File: rtl/nios_cpu_mul_sequencer.sv
// Drives the shared 16x16 three-partial-product cell in a low pass and, for the
// high-word ops, a second hi*hi pass, accumulating into a 64-bit product.
module nios_cpu_mul_sequencer
    import nios_cpu_mul_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CELL_LATENCY - 1);

    mul_state_e       r_state;
    mul_op_e          r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [63:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_result;
    logic [31:0]      r_cell_src1;
    logic [31:0]      r_cell_src2;
    logic             r_cell_en;

    logic [63:0]      w_acc_lo;
    logic [63:0]      w_acc_hi;
    logic [63:0]      w_acc_next;
    logic [31:0]      w_result;

    // Low pass sums lo*lo with both cross terms; high pass adds hi*hi (arrives on p1)
    assign w_acc_lo   = {32'd0, cell_p1} + {16'd0, cell_p2, 16'd0} + {16'd0, cell_p3, 16'd0};
    assign w_acc_hi   = r_acc + {cell_p1, 32'd0};
    assign w_acc_next = (r_state == HI_WAIT) ? w_acc_hi : w_acc_lo;

    nios_cpu_mul_fixup u_fixup (
        .i_acc    (w_acc_next),
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_op         <= MUL;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_cell_src1  <= '0;
            r_cell_src2  <= '0;
            r_cell_en    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op        <= mul_op_e'(req_op);
                        r_a         <= req_src1;
                        r_b         <= req_src2;
                        r_cell_src1 <= req_src1;
                        r_cell_src2 <= req_src2;
                        r_cell_en   <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= LO;
                    end
                end
                LO: begin
                    r_cell_en <= 1'b0;
                    r_cnt     <= CNT_LOAD;
                    r_state   <= LO_WAIT;
                end
                LO_WAIT: begin
                    if (r_cnt == '0) begin
                        r_acc <= w_acc_lo;
                        if (r_op == MUL) begin
                            r_rsp_result <= w_result;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_cell_src1 <= {16'd0, r_a[31:16]};
                            r_cell_src2 <= {16'd0, r_b[31:16]};
                            r_cell_en   <= 1'b1;
                            r_state     <= HI;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HI: begin
                    r_cell_en <= 1'b0;
                    r_cnt     <= CNT_LOAD;
                    r_state   <= HI_WAIT;
                end
                HI_WAIT: begin
                    if (r_cnt == '0) begin
                        r_acc        <= w_acc_hi;
                        r_rsp_result <= w_result;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cell_en   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign cell_src1  = r_cell_src1;
    assign cell_src2  = r_cell_src2;
    assign cell_en    = r_cell_en;

endmodule

// File: tb/tb_nios_cpu_mul_sequencer.sv
// Bench for the multiply sequencer at CELL_LATENCY 1 and 3, each DUT paired with
// a behavioural partial-product cell; results checked against a 64-bit product model.
module tb_nios_cpu_mul_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, req_valid, rsp_ready, sel;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;

    logic        d1_req_ready, d1_rsp_valid, d1_cell_en;
    logic [31:0] d1_rsp_result, d1_cell_src1, d1_cell_src2, d1_p1, d1_p2, d1_p3;
    logic        d3_req_ready, d3_rsp_valid, d3_cell_en;
    logic [31:0] d3_rsp_result, d3_cell_src1, d3_cell_src2, d3_p1, d3_p2, d3_p3;

    int checks = 0;
    int errors = 0;

    nios_cpu_mul_sequencer #(.CELL_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & ~sel), .req_ready(d1_req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(d1_rsp_result),
        .cell_src1(d1_cell_src1), .cell_src2(d1_cell_src2), .cell_en(d1_cell_en),
        .cell_p1(d1_p1), .cell_p2(d1_p2), .cell_p3(d1_p3)
    );

    nios_cpu_mul_sequencer #(.CELL_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & sel), .req_ready(d3_req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(d3_rsp_result),
        .cell_src1(d3_cell_src1), .cell_src2(d3_cell_src2), .cell_en(d3_cell_en),
        .cell_p1(d3_p1), .cell_p2(d3_p2), .cell_p3(d3_p3)
    );

    // Multiplier cell: {p1, p2, p3} = {lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2)}
    function automatic logic [95:0] cell_f(input logic [31:0] s1, input logic [31:0] s2);
        logic [31:0] q1, q2, q3;
        q1 = 32'(s1[15:0]) * 32'(s2[15:0]);
        q2 = 32'(s1[15:0]) * 32'(s2[31:16]);
        q3 = 32'(s1[31:16]) * 32'(s2[15:0]);
        return {q1, q2, q3};
    endfunction

    always_ff @(posedge clk)
        if (d1_cell_en) {d1_p1, d1_p2, d1_p3} <= cell_f(d1_cell_src1, d1_cell_src2);

    logic [95:0] c3_s0, c3_s1, c3_s2;
    always_ff @(posedge clk) begin
        if (d3_cell_en) c3_s0 <= cell_f(d3_cell_src1, d3_cell_src2);
        c3_s1 <= c3_s0;
        c3_s2 <= c3_s1;
    end
    assign {d3_p1, d3_p2, d3_p3} = c3_s2;

    logic        m_req_ready, m_rsp_valid, m_cell_en;
    logic [31:0] m_rsp_result, m_cell_src1, m_cell_src2;
    assign m_req_ready  = sel ? d3_req_ready  : d1_req_ready;
    assign m_rsp_valid  = sel ? d3_rsp_valid  : d1_rsp_valid;
    assign m_cell_en    = sel ? d3_cell_en    : d1_cell_en;
    assign m_rsp_result = sel ? d3_rsp_result : d1_rsp_result;
    assign m_cell_src1  = sel ? d3_cell_src1  : d1_cell_src1;
    assign m_cell_src2  = sel ? d3_cell_src2  : d1_cell_src2;

    // Reference: full 64-bit product of the operands extended per op signedness
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, pr;
        ea = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'd2) ? {{32{b[31]}}, b} : {32'd0, b};
        pr = ea * eb;
        return (op == 2'd0) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        int l;
        l = sel ? 3 : 1;
        return (op == 2'd0) ? 2 + l : 3 + 2 * l;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Issues one request and runs to the first cycle with rsp_valid, leaving rsp_ready low
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int ens, output bit ok);
        res = '0; lat = 0; ens = 0; ok = 1'b0;
        if (m_req_ready !== 1'b1) return;
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom()); req_src1 = $urandom(); req_src2 = $urandom();
        for (int c = 1; c <= 40; c++) begin
            if (m_cell_en === 1'b1) ens++;
            if (m_rsp_valid === 1'b1) begin
                res = m_rsp_result; lat = c; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready L%0d: got %b want 1", s*2+1, m_req_ready); end
            checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid L%0d: got %b want 0", s*2+1, m_rsp_valid); end
            checks++; if (m_rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result L%0d: got %h want 0", s*2+1, m_rsp_result); end
            checks++; if (m_cell_en !== 1'b0) begin errors++; $display("FAIL reset_cell_en L%0d: got %b want 0", s*2+1, m_cell_en); end
            checks++; if (m_cell_src1 !== 32'd0) begin errors++; $display("FAIL reset_cell_src1 L%0d: got %h want 0", s*2+1, m_cell_src1); end
            checks++; if (m_cell_src2 !== 32'd0) begin errors++; $display("FAIL reset_cell_src2 L%0d: got %h want 0", s*2+1, m_cell_src2); end
        end
        sel = 1'b0;
    endtask

    localparam logic [1:0]  D_OP  [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    localparam logic [31:0] D_A   [6] = '{32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    localparam logic [31:0] D_B   [6] = '{32'h0002_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFF};
    localparam logic [31:0] D_EXP [6] = '{32'h000B_000F, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

    task automatic test_directed();
        logic [31:0] res; int lat, ens; bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op(D_OP[i], D_A[i], D_B[i], res, lat, ens, ok);
            checks++; if (!ok) begin errors++; $display("FAIL dir%0d_timeout L%0d: no rsp_valid within bound", i, sel ? 3 : 1); end
            checks++; if (res !== D_EXP[i]) begin errors++; $display("FAIL dir%0d_result L%0d: got %h want %h", i, sel ? 3 : 1, res, D_EXP[i]); end
            checks++; if (lat != exp_lat(D_OP[i])) begin errors++; $display("FAIL dir%0d_latency L%0d: got %0d want %0d", i, sel ? 3 : 1, lat, exp_lat(D_OP[i])); end
            checks++; if (ens != ((D_OP[i] == 2'd0) ? 1 : 2)) begin errors++; $display("FAIL dir%0d_cell_en L%0d: got %0d pulses want %0d", i, sel ? 3 : 1, ens, (D_OP[i] == 2'd0) ? 1 : 2); end
            release_rsp();
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] a, b, res, exp; logic [1:0] op; int lat, ens; bit ok;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
            exp = ref_mul(op, a, b);
            run_op(op, a, b, res, lat, ens, ok);
            checks++; if (!ok || res !== exp) begin errors++; $display("FAIL rand%0d op%0d a=%h b=%h L%0d: got %h want %h", i, op, a, b, sel ? 3 : 1, res, exp); end
            checks++; if (lat != exp_lat(op) || ens != ((op == 2'd0) ? 1 : 2)) begin errors++; $display("FAIL rand%0d_timing L%0d: got lat %0d en %0d want lat %0d", i, sel ? 3 : 1, lat, ens, exp_lat(op)); end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            release_rsp();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res, first; int lat, ens; bit ok;
        a = $urandom(); b = $urandom();
        run_op(2'd2, a, b, first, lat, ens, ok);
        checks++; if (!ok || first !== ref_mul(2'd2, a, b)) begin errors++; $display("FAIL bp_result L%0d: got %h want %h", sel ? 3 : 1, first, ref_mul(2'd2, a, b)); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_rsp_valid !== 1'b1 || m_rsp_result !== first || m_req_ready !== 1'b0 || m_cell_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d L%0d: got valid %b result %h ready %b en %b want 1 %h 0 0", i, sel ? 3 : 1, m_rsp_valid, m_rsp_result, m_req_ready, m_cell_en, first);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle L%0d: got ready %b valid %b want 1 0", sel ? 3 : 1, m_req_ready, m_rsp_valid); end
        a = $urandom(); b = $urandom();
        run_op(2'd0, a, b, res, lat, ens, ok);
        checks++; if (!ok || res !== ref_mul(2'd0, a, b) || lat != exp_lat(2'd0)) begin errors++; $display("FAIL b2b L%0d: got %h lat %0d want %h lat %0d", sel ? 3 : 1, res, lat, ref_mul(2'd0, a, b), exp_lat(2'd0)); end
        release_rsp();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, res; int lat, ens, seen; bit ok;
        req_valid = 1'b1; req_op = 2'd1; req_src1 = $urandom(); req_src2 = $urandom();
        @(posedge clk); #1;
        req_valid = 1'b0;
        // advance from the LO cycle to the first HI_WAIT cycle
        repeat ((sel ? 3 : 1) + 2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++; if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_cell_en !== 1'b0) begin errors++; $display("FAIL midrst_state L%0d: got ready %b valid %b en %b want 1 0 0", sel ? 3 : 1, m_req_ready, m_rsp_valid, m_cell_en); end
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (m_rsp_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp L%0d: got %0d valid cycles want 0", sel ? 3 : 1, seen); end
        a = $urandom(); b = $urandom();
        run_op(2'd3, a, b, res, lat, ens, ok);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++; if (!ok || res !== ref_mul(2'd3, a, b)) begin errors++; $display("FAIL rsprst_result L%0d: got %h want %h", sel ? 3 : 1, res, ref_mul(2'd3, a, b)); end
        checks++; if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b1) begin errors++; $display("FAIL rsprst_state L%0d: got valid %b ready %b want 0 1", sel ? 3 : 1, m_rsp_valid, m_req_ready); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
        req_op = 2'd0; req_src1 = '0; req_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            test_directed();
            test_random(40);
            test_back_to_back();
            test_reset_mid();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
